// File: rtl/ysyx_24070014_mem_arbiter.sv
// Purpose: shares one memory request/response port between the IFU and the LSU with round-robin grants.
// Latency: the request is registered on acceptance, is presented to memory the next cycle, and the response is forwarded combinationally.
// Backpressure: only one transaction is outstanding; both req_ready outputs stay low until the response returns.
module ysyx_24070014_mem_arbiter #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_req_valid,
  input  logic [ADDR_LEN-1:0]   ifu_req_addr,
  output logic                  ifu_req_ready,
  output logic                  ifu_resp_valid,
  output logic [DATA_LEN-1:0]   ifu_resp_data,
  input  logic                  lsu_req_valid,
  input  logic [ADDR_LEN-1:0]   lsu_req_addr,
  input  logic                  lsu_req_wen,
  input  logic [DATA_LEN-1:0]   lsu_req_wdata,
  input  logic [DATA_LEN/8-1:0] lsu_req_wmask,
  output logic                  lsu_req_ready,
  output logic                  lsu_resp_valid,
  output logic [DATA_LEN-1:0]   lsu_resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_LEN-1:0]   mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_LEN-1:0]   mem_req_wdata,
  output logic [DATA_LEN/8-1:0] mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_LEN-1:0]   mem_resp_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_next;
  logic   owner_lsu;       // 1 = outstanding transaction belongs to the LSU
  logic   last_grant_lsu;  // 1 = LSU won the most recent grant
  logic   grant_ifu, grant_lsu;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_grant_lsu);
    grant_ifu = ifu_req_valid && !grant_lsu;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake/response outputs; readies are also masked while reset is held.
  always_comb begin
    state_next     = state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_data  = '0;
    lsu_resp_valid = 1'b0;
    lsu_resp_data  = '0;
    case (state)
      IDLE: begin
        if (reset) begin
          ifu_req_ready = grant_ifu;
          lsu_req_ready = grant_lsu;
          if (grant_ifu || grant_lsu) state_next = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          if (owner_lsu) begin
            lsu_resp_valid = 1'b1;
            // Stores are acknowledged with zero data.
            lsu_resp_data  = mem_req_wen ? '0 : mem_resp_data;
          end else begin
            ifu_resp_valid = 1'b1;
            ifu_resp_data  = mem_resp_data;
          end
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the granted request, its owner and the round-robin history on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_lsu      <= 1'b0;
      last_grant_lsu <= 1'b1;
      mem_req_addr   <= '0;
      mem_req_wen    <= 1'b0;
      mem_req_wdata  <= '0;
      mem_req_wmask  <= '0;
    end else if (state == IDLE && (grant_ifu || grant_lsu)) begin
      owner_lsu      <= grant_lsu;
      last_grant_lsu <= grant_lsu;
      mem_req_addr   <= grant_lsu ? lsu_req_addr : ifu_req_addr;
      mem_req_wen    <= grant_lsu && lsu_req_wen;
      mem_req_wdata  <= grant_lsu ? lsu_req_wdata : '0;
      mem_req_wmask  <= grant_lsu ? lsu_req_wmask : '0;
    end
  end

endmodule

// File: tb/tb_ysyx_24070014_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter.
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns later.
// Responses have no backpressure, so every pulse is checked in its own cycle.
module tb_ysyx_24070014_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_valid;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24070014_mem_arbiter #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge, ready to drive inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ifu_rdy"},   ifu_req_ready, 0);
    chk({tag, "_lsu_rdy"},   lsu_req_ready, 0);
    chk({tag, "_ifu_rv"},    ifu_resp_valid, 0);
    chk({tag, "_lsu_rv"},    lsu_resp_valid, 0);
    chk({tag, "_ifu_rd"},    ifu_resp_data, 0);
    chk({tag, "_lsu_rd"},    lsu_resp_data, 0);
    chk({tag, "_mem_vld"},   mem_req_valid, 0);
    chk({tag, "_mem_addr"},  mem_req_addr, 0);
    chk({tag, "_mem_wen"},   mem_req_wen, 0);
    chk({tag, "_mem_wdata"}, mem_req_wdata, 0);
    chk({tag, "_mem_wmask"}, mem_req_wmask, 0);
  endtask

  initial begin
    logic exp_ifu;
    logic [31:0] exp_addr;
    logic [31:0] rdata;

    // Reset asserted with every input driven high.
    reset = 1'b1;
    ifu_req_valid = 0; ifu_req_addr = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    #3 reset = 1'b0;
    ifu_req_valid = 1; ifu_req_addr = '1;
    lsu_req_valid = 1; lsu_req_addr = '1; lsu_req_wen = 1; lsu_req_wdata = '1; lsu_req_wmask = '1;
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = '1;
    #1 check_all_zero("rst_early");
    repeat (3) tick();
    #1 check_all_zero("rst_held");

    // Release with only the IFU requesting: granted in the first cycle.
    tick();
    reset = 1'b1;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    mem_resp_valid = 0; mem_resp_data = 0;
    ifu_req_addr = 32'h8000_0000;
    #1 chk("rel_ifu_rdy", ifu_req_ready, 1);
    chk("rel_lsu_rdy", lsu_req_ready, 0);

    // Single fetch; requester fields change after acceptance.
    tick();
    ifu_req_valid = 0; ifu_req_addr = 32'h1234_5678;
    #1 chk("fetch_mem_vld", mem_req_valid, 1);
    chk("fetch_mem_addr", mem_req_addr, 32'h8000_0000);
    chk("fetch_mem_wen", mem_req_wen, 0);
    chk("fetch_mem_wmask", mem_req_wmask, 0);
    chk("fetch_ifu_rdy_busy", ifu_req_ready, 0);
    tick();
    mem_resp_valid = 1; mem_resp_data = 32'h0010_0073;
    #1 chk("fetch_ifu_rv", ifu_resp_valid, 1);
    chk("fetch_ifu_rd", ifu_resp_data, 32'h0010_0073);
    chk("fetch_lsu_rv", lsu_resp_valid, 0);
    chk("fetch_wait_mem_vld", mem_req_valid, 0);
    tick();
    mem_resp_valid = 0;
    #1 chk("fetch_ifu_rv_end", ifu_resp_valid, 0);
    chk("fetch_idle_mem_vld", mem_req_valid, 0);

    // Store with memory stalling for three REQ cycles.
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF; mem_req_ready = 0;
    #1 chk("st_lsu_rdy", lsu_req_ready, 1);
    chk("st_ifu_rdy", ifu_req_ready, 0);
    tick();
    lsu_req_valid = 0; lsu_req_wdata = 32'h0; lsu_req_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready  = (i == 3);
      mem_resp_valid = (i == 1); // spurious response while in REQ
      #1 chk($sformatf("st_req%0d_vld", i), mem_req_valid, 1);
      chk($sformatf("st_req%0d_addr", i), mem_req_addr, 32'h8000_1000);
      chk($sformatf("st_req%0d_wen", i), mem_req_wen, 1);
      chk($sformatf("st_req%0d_wdata", i), mem_req_wdata, 32'hDEAD_BEEF);
      chk($sformatf("st_req%0d_wmask", i), mem_req_wmask, 4'hF);
      chk($sformatf("st_req%0d_lsu_rv", i), lsu_resp_valid, 0);
      chk($sformatf("st_req%0d_ifu_rv", i), ifu_resp_valid, 0);
      tick();
    end
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h1234_5678;
    #1 chk("st_lsu_rv", lsu_resp_valid, 1);
    chk("st_lsu_rd_zero", lsu_resp_data, 0);
    chk("st_ifu_rv", ifu_resp_valid, 0);
    tick();

    // Spurious response in IDLE: nothing delivered, no request launched.
    mem_resp_valid = 1; mem_resp_data = 32'hFFFF_FFFF;
    #1 chk("spur_idle_ifu_rv", ifu_resp_valid, 0);
    chk("spur_idle_lsu_rv", lsu_resp_valid, 0);
    tick();
    mem_resp_valid = 0;
    #1 chk("spur_idle_mem_vld", mem_req_valid, 0);

    // Continuous contention: last grant was LSU, so IFU leads and grants alternate.
    ifu_req_valid = 1; ifu_req_addr = 32'h0000_0100;
    lsu_req_valid = 1; lsu_req_addr = 32'h0000_0200; lsu_req_wen = 0;
    lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0; mem_req_ready = 1;
    for (int t = 0; t < 6; t++) begin
      exp_ifu  = (t % 2 == 0);
      exp_addr = exp_ifu ? 32'h0000_0100 : 32'h0000_0200;
      rdata    = 32'hA000_0000 + t;
      #1 chk($sformatf("cont%0d_ifu_rdy", t), ifu_req_ready, exp_ifu);
      chk($sformatf("cont%0d_lsu_rdy", t), lsu_req_ready, !exp_ifu);
      tick();
      #1 chk($sformatf("cont%0d_mem_addr", t), mem_req_addr, exp_addr);
      chk($sformatf("cont%0d_mem_vld", t), mem_req_valid, 1);
      tick();
      mem_resp_valid = 1; mem_resp_data = rdata;
      #1 chk($sformatf("cont%0d_ifu_rv", t), ifu_resp_valid, exp_ifu);
      chk($sformatf("cont%0d_lsu_rv", t), lsu_resp_valid, !exp_ifu);
      chk($sformatf("cont%0d_rd", t), exp_ifu ? ifu_resp_data : lsu_resp_data, rdata);
      tick();
      mem_resp_valid = 0;
    end

    // Reset while a load is outstanding, then a late response.
    ifu_req_valid = 0;
    lsu_req_valid = 1; lsu_req_addr = 32'h0000_0300; lsu_req_wen = 0;
    #1 chk("rw_lsu_rdy", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 0;
    tick();
    #1 chk("rw_wait_mem_vld", mem_req_valid, 0);
    reset = 1'b0;
    #1 check_all_zero("rw_rst");
    tick();
    reset = 1'b1; mem_resp_valid = 1; mem_resp_data = 32'h5555_AAAA;
    #1 chk("rw_late_lsu_rv", lsu_resp_valid, 0);
    chk("rw_late_ifu_rv", ifu_resp_valid, 0);
    chk("rw_late_lsu_rd", lsu_resp_data, 0);
    tick();
    mem_resp_valid = 0;
    ifu_req_valid = 1; lsu_req_valid = 1;
    #1 chk("rw_idle_ifu_rdy", ifu_req_ready, 1);
    chk("rw_idle_lsu_rdy", lsu_req_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
